// File: rtl/psum_accumulator_if.sv
// Stream bundle between the PE-array column tops, the psum accumulator and the ofmap writer.
// master = producer/consumer side (PE array + ofmap writer), slave = accumulator.
interface psum_accumulator_if #(
   parameter int PE_WIDTH  = 4,
   parameter int ACC_WIDTH = 12
);
   logic [PE_WIDTH-1:0]  psum_in_0;
   logic [PE_WIDTH-1:0]  psum_in_1;
   logic [PE_WIDTH-1:0]  psum_in_2;
   logic                 psum_valid;
   logic                 in_ready;
   logic                 pass_first;
   logic                 pass_last;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic                 acc_ovf;

   modport master (
      output psum_in_0, psum_in_1, psum_in_2, psum_valid, pass_first, pass_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, acc_ovf
   );

   modport slave (
      input  psum_in_0, psum_in_1, psum_in_2, psum_valid, pass_first, pass_last, out_ready,
      output in_ready, out_data, out_valid, out_last, acc_ovf
   );
endinterface

// File: rtl/psum_accumulator.sv
// Sums the three PE column psums per beat into a DEPTH-entry row buffer across channel passes,
// then drains the row as a valid/ready stream. Define PSUM_SAT_EN to saturate instead of wrap.
module psum_accumulator #(
   parameter int PE_WIDTH  = 4,
   parameter int ACC_WIDTH = 12,
   parameter int DEPTH     = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   psum_accumulator_if.slave     io_psum
);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CS_W   = PE_WIDTH + 2;
   localparam int ACC_W1 = ACC_WIDTH + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_wr_idx;
   logic [IDX_W-1:0]     r_rd_idx;
   logic [ACC_WIDTH-1:0] r_acc [DEPTH];
   logic                 r_pass_first;
   logic                 r_pass_last;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [ACC_WIDTH-1:0] r_out_data;
   logic                 r_acc_ovf;

   logic [CS_W-1:0]      w_col_sum;
   logic                 w_accept;
   logic                 w_first;
   logic                 w_last;
   logic [ACC_W1-1:0]    w_acc_ext;
   logic                 w_carry;
   logic [ACC_WIDTH-1:0] w_wr_val;
   logic                 w_wr_at_end;
   logic [IDX_W-1:0]     w_rd_next;
   logic                 w_out_hs;

   // Beat datapath: column sum, pass flags for this beat and the value to store.
   always_comb begin
      w_col_sum   = CS_W'(io_psum.psum_in_0) + CS_W'(io_psum.psum_in_1)
                  + CS_W'(io_psum.psum_in_2);
      w_accept    = io_psum.psum_valid && r_in_ready;
      w_wr_at_end = (r_wr_idx == LAST_IDX);
      w_rd_next   = r_rd_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      w_out_hs    = r_out_valid && io_psum.out_ready;
      // Flags are sampled only on the index-0 beat and held for the rest of the pass.
      if (r_wr_idx == {IDX_W{1'b0}}) begin
         w_first = io_psum.pass_first;
         w_last  = io_psum.pass_last;
      end else begin
         w_first = r_pass_first;
         w_last  = r_pass_last;
      end
      w_acc_ext = {1'b0, r_acc[r_wr_idx]} + ACC_W1'(w_col_sum);
      w_carry   = w_acc_ext[ACC_WIDTH] && !w_first;
      if (w_first) begin
         w_wr_val = ACC_WIDTH'(w_col_sum);
      end else if (w_carry) begin
`ifdef PSUM_SAT_EN
         w_wr_val = {ACC_WIDTH{1'b1}};
`else
         w_wr_val = w_acc_ext[ACC_WIDTH-1:0];
`endif
      end else begin
         w_wr_val = w_acc_ext[ACC_WIDTH-1:0];
      end
   end

   // Row buffer write port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_acc[i] <= {ACC_WIDTH{1'b0}};
         end
      end else if (r_state == ST_ACCUM && w_accept) begin
         r_acc[r_wr_idx] <= w_wr_val;
      end
   end

   // Control FSM with registered stream outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_ACCUM;
         r_wr_idx     <= {IDX_W{1'b0}};
         r_rd_idx     <= {IDX_W{1'b0}};
         r_pass_first <= 1'b0;
         r_pass_last  <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= {ACC_WIDTH{1'b0}};
         r_acc_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  r_pass_first <= w_first;
                  r_pass_last  <= w_last;
                  if (w_carry) begin
                     r_acc_ovf <= 1'b1;
                  end
                  if (w_wr_at_end) begin
                     r_wr_idx <= {IDX_W{1'b0}};
                     // Entry 0 is already final here since the last write targets DEPTH-1.
                     if (w_last) begin
                        r_state     <= ST_DRAIN;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc[0];
                        r_out_last  <= 1'b0;
                        r_rd_idx    <= {IDX_W{1'b0}};
                     end
                  end else begin
                     r_wr_idx <= r_wr_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_DRAIN: begin
               if (w_out_hs) begin
                  if (r_out_last) begin
                     r_state     <= ST_ACCUM;
                     r_rd_idx    <= {IDX_W{1'b0}};
                     r_wr_idx    <= {IDX_W{1'b0}};
                     r_acc_ovf   <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= {ACC_WIDTH{1'b0}};
                  end else begin
                     r_rd_idx   <= w_rd_next;
                     r_out_data <= r_acc[w_rd_next];
                     r_out_last <= (w_rd_next == LAST_IDX);
                  end
               end
            end
            default: begin
               r_state     <= ST_ACCUM;
               r_wr_idx    <= {IDX_W{1'b0}};
               r_rd_idx    <= {IDX_W{1'b0}};
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_out_data  <= {ACC_WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign io_psum.in_ready  = r_in_ready;
   assign io_psum.out_valid = r_out_valid;
   assign io_psum.out_last  = r_out_last;
   assign io_psum.out_data  = r_out_data;
   assign io_psum.acc_ovf   = r_acc_ovf;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of pass/drain scenarios on a 12-bit instance,
// plus reset-mid-drain and a 6-bit instance exercising overflow (wrap or PSUM_SAT_EN clamp).
module tb_psum_accumulator;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   psum_accumulator_if #(.PE_WIDTH(4), .ACC_WIDTH(12)) bus ();
   psum_accumulator_if #(.PE_WIDTH(4), .ACC_WIDTH(6))  nbus ();

   psum_accumulator #(.PE_WIDTH(4), .ACC_WIDTH(12), .DEPTH(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .io_psum(bus.slave)
   );
   psum_accumulator #(.PE_WIDTH(4), .ACC_WIDTH(6), .DEPTH(8)) dut_narrow (
      .i_clk(clk), .i_rst_n(rst_n), .io_psum(nbus.slave)
   );

`ifdef PSUM_SAT_EN
   localparam int NARROW_EXP = 63;
`else
   localparam int NARROW_EXP = 26;
`endif

   typedef struct {
      int npass;
      int a;
      int b;
      int c;
      bit vary;
      bit bp;
      bit junk;
      int word;
      bit ovf;
   } vec_t;

   vec_t vecs [6];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int npass, input int a, input int b, input int c, input bit vary);
      for (int q = 0; q < npass; q++) begin
         for (int i = 0; i < 8; i++) begin
            bus.psum_valid = 1'b1;
            bus.psum_in_0  = vary ? 4'(i) : 4'(a);
            bus.psum_in_1  = 4'(b);
            bus.psum_in_2  = 4'(c);
            bus.pass_first = (i == 0) && (q == 0);
            bus.pass_last  = (i == 0) && (q == npass - 1);
            if (i == 0) check("in_ready_pass_start", {31'd0, bus.in_ready}, 32'd1);
            step();
         end
      end
      bus.psum_valid = 1'b0;
      bus.pass_first = 1'b0;
      bus.pass_last  = 1'b0;
   endtask

   task automatic drain(input int word, input bit vary, input bit bp, input bit junk);
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      check("drain_latency", {31'd0, bus.out_valid}, 32'd1);
      while (k < 8 && cyc < 200) begin
         bus.out_ready  = bp ? (cyc % 2 == 0) : 1'b1;
         bus.psum_valid = junk;
         if (junk) begin
            bus.psum_in_0 = 4'd15;
            bus.psum_in_1 = 4'd15;
            bus.psum_in_2 = 4'd15;
         end
         check("out_valid_drain", {31'd0, bus.out_valid}, 32'd1);
         if (bus.out_valid) begin
            check("out_data", {20'd0, bus.out_data}, vary ? k : word);
            if (bus.out_ready) begin
               check("out_last", {31'd0, bus.out_last}, (k == 7) ? 32'd1 : 32'd0);
               k++;
            end
         end
         step();
         cyc++;
      end
      bus.out_ready  = 1'b0;
      bus.psum_valid = 1'b0;
      check("drain_count", k, 32'd8);
      check("out_valid_after", {31'd0, bus.out_valid}, 32'd0);
      check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{npass: 1, a: 1,  b: 2,  c: 3,  vary: 1'b0, bp: 1'b0, junk: 1'b0, word: 6,   ovf: 1'b0};
      vecs[1] = '{npass: 3, a: 15, b: 15, c: 15, vary: 1'b0, bp: 1'b0, junk: 1'b0, word: 135, ovf: 1'b0};
      vecs[2] = '{npass: 1, a: 4,  b: 5,  c: 6,  vary: 1'b0, bp: 1'b1, junk: 1'b0, word: 15,  ovf: 1'b0};
      vecs[3] = '{npass: 1, a: 15, b: 15, c: 15, vary: 1'b0, bp: 1'b0, junk: 1'b1, word: 45,  ovf: 1'b0};
      vecs[4] = '{npass: 1, a: 0,  b: 0,  c: 0,  vary: 1'b1, bp: 1'b0, junk: 1'b0, word: 0,   ovf: 1'b0};
      vecs[5] = '{npass: 2, a: 0,  b: 0,  c: 1,  vary: 1'b0, bp: 1'b1, junk: 1'b0, word: 2,   ovf: 1'b0};

      rst_n = 1'b0;
      bus.psum_in_0 = 4'd0;  bus.psum_in_1 = 4'd0;  bus.psum_in_2 = 4'd0;
      bus.psum_valid = 1'b0; bus.pass_first = 1'b0; bus.pass_last = 1'b0; bus.out_ready = 1'b0;
      nbus.psum_in_0 = 4'd0; nbus.psum_in_1 = 4'd0; nbus.psum_in_2 = 4'd0;
      nbus.psum_valid = 1'b0; nbus.pass_first = 1'b0; nbus.pass_last = 1'b0; nbus.out_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_out_data", {20'd0, bus.out_data}, 32'd0);
      check("rst_acc_ovf", {31'd0, bus.acc_ovf}, 32'd0);
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 6; v++) begin
         send(vecs[v].npass, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].vary);
         check("acc_ovf", {31'd0, bus.acc_ovf}, {31'd0, vecs[v].ovf});
         drain(vecs[v].word, vecs[v].vary, vecs[v].bp, vecs[v].junk);
         step();
      end

      // Reset after three drained words, then a fresh single pass.
      send(1, 1, 1, 1, 1'b0);
      bus.out_ready = 1'b1;
      repeat (3) step();
      check("mid_drain_valid", {31'd0, bus.out_valid}, 32'd1);
      check("mid_drain_data", {20'd0, bus.out_data}, 32'd3);
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_mid_out_data", {20'd0, bus.out_data}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      send(1, 0, 0, 1, 1'b0);
      drain(1, 1'b0, 1'b0, 1'b0);
      step();

      // Narrow accumulator: 45 + 45 overflows 6 bits.
      for (int q = 0; q < 2; q++) begin
         for (int i = 0; i < 8; i++) begin
            nbus.psum_valid = 1'b1;
            nbus.psum_in_0  = 4'd15;
            nbus.psum_in_1  = 4'd15;
            nbus.psum_in_2  = 4'd15;
            nbus.pass_first = (i == 0) && (q == 0);
            nbus.pass_last  = (i == 0) && (q == 1);
            step();
         end
      end
      nbus.psum_valid = 1'b0;
      nbus.pass_first = 1'b0;
      nbus.pass_last  = 1'b0;
      check("narrow_ovf", {31'd0, nbus.acc_ovf}, 32'd1);
      nbus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("narrow_valid", {31'd0, nbus.out_valid}, 32'd1);
         check("narrow_data", {26'd0, nbus.out_data}, NARROW_EXP);
         check("narrow_last", {31'd0, nbus.out_last}, (k == 7) ? 32'd1 : 32'd0);
         step();
      end
      nbus.out_ready = 1'b0;
      check("narrow_valid_after", {31'd0, nbus.out_valid}, 32'd0);
      check("narrow_ovf_cleared", {31'd0, nbus.acc_ovf}, 32'd0);
      check("narrow_in_ready", {31'd0, nbus.in_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
